// File: rtl/rv_bus_pkg.sv
// Shared types and bus encodings for the CPU external memory bus.
// Used by the I/D arbiter and its ack-timeout counter.
package rv_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic BUS_RD    = 1'b1;
  localparam logic BUS_WR    = 1'b0;
  localparam logic BUS_INSTR = 1'b1;
  localparam logic BUS_DATA  = 1'b0;

endpackage

// File: rtl/rv_bus_timeout.sv
// Ack-wait counter: expired flags the last waiting cycle of a TIMEOUT-cycle window.
// TIMEOUT=0 removes the counter entirely and never expires.
module rv_bus_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_cnt
      localparam int CW = $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] count_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else if (clr) begin
          count_reg <= '0;
        end else if (en) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      // Flag on the cycle whose increment would reach TIMEOUT so the error
      // response lands TIMEOUT cycles after ads, like an ack would.
      assign expired = en && (count_reg == LAST);
    end else begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clr, en};
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rv_mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and load/store onto the
// external CPU bus, with round-robin on conflict and an ack timeout.
module rv_mem_arbiter
  import rv_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_be,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            ads,
  output logic            rd_wr_n,
  output logic            i_dn,
  output logic [AW-1:0]   addr,
  output logic [DW/8-1:0] be,
  output logic [DW-1:0]   wr_data,
  input  logic [DW-1:0]   rd_data,
  input  logic            ack
);

  bus_state_e state_reg;
  port_e      last_served_reg;
  logic       idle;
  logic       busy;
  logic       accept;
  logic       expired;

  assign idle   = (state_reg == ST_IDLE);
  assign busy   = (state_reg == ST_ADDR) || (state_reg == ST_WAIT);
  assign i_gnt  = idle && i_req && (!d_req || (last_served_reg == PORT_D));
  assign d_gnt  = idle && d_req && (!i_req || (last_served_reg == PORT_I));
  assign accept = i_gnt || d_gnt;
  assign ads    = (state_reg == ST_ADDR);

  rv_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (busy && !ack),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      last_served_reg <= PORT_I;
      rd_wr_n         <= BUS_RD;
      i_dn            <= BUS_INSTR;
      addr            <= '0;
      be              <= '0;
      wr_data         <= '0;
      i_rvalid        <= 1'b0;
      i_err           <= 1'b0;
      i_rdata         <= '0;
      d_rvalid        <= 1'b0;
      d_err           <= 1'b0;
      d_rdata         <= '0;
    end else begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_gnt) begin
            state_reg       <= ST_ADDR;
            last_served_reg <= PORT_I;
            i_dn            <= BUS_INSTR;
            rd_wr_n         <= BUS_RD;
            addr            <= i_addr;
            be              <= '1;
            wr_data         <= '0;
          end else if (d_gnt) begin
            state_reg       <= ST_ADDR;
            last_served_reg <= PORT_D;
            i_dn            <= BUS_DATA;
            rd_wr_n         <= d_we ? BUS_WR : BUS_RD;
            addr            <= d_addr;
            be              <= d_be;
            wr_data         <= d_we ? d_wdata : '0;
          end
        end
        ST_ADDR, ST_WAIT: begin
          // ack takes priority over an expiring count in the same cycle.
          if (ack) begin
            state_reg <= ST_IDLE;
            if (i_dn == BUS_INSTR) begin
              i_rvalid <= 1'b1;
              i_rdata  <= rd_data;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= (rd_wr_n == BUS_RD) ? rd_data : '0;
            end
          end else if (expired) begin
            state_reg <= ST_IDLE;
            if (i_dn == BUS_INSTR) begin
              i_rvalid <= 1'b1;
              i_err    <= 1'b1;
              i_rdata  <= '0;
            end else begin
              d_rvalid <= 1'b1;
              d_err    <= 1'b1;
              d_rdata  <= '0;
            end
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter with a response scoreboard (TIMEOUT=4).
module tb_rv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_req = 1'b0;
  logic [AW-1:0]   i_addr = '0;
  logic            i_gnt, i_rvalid, i_err;
  logic [DW-1:0]   i_rdata;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [AW-1:0]   d_addr = '0;
  logic [DW/8-1:0] d_be = '0;
  logic [DW-1:0]   d_wdata = '0;
  logic            d_gnt, d_rvalid, d_err;
  logic [DW-1:0]   d_rdata;
  logic            ads, rd_wr_n, i_dn;
  logic [AW-1:0]   addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   rd_data = '0;
  logic            ack = 1'b0;

  typedef struct {
    logic        is_i;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ads(ads), .rd_wr_n(rd_wr_n), .i_dn(i_dn), .addr(addr), .be(be),
    .wr_data(wr_data), .rd_data(rd_data), .ack(ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_i, input logic err, input logic [31:0] data);
    exp_t e;
    e.is_i = is_i;
    e.err  = err;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic resp(input logic is_i, input logic [31:0] data, input logic err);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL rvalid_unexpected: observed response on %s port, expected none",
             is_i ? "I" : "D");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("resp_port", 32'(is_i), 32'(e.is_i));
      chk("resp_data", data, e.data);
      chk("resp_err", 32'(err), 32'(e.err));
      $display("[%0t] resp port=%s data=0x%08h err=%0b", $time, is_i ? "I" : "D", data, err);
    end
  endtask

  // Response monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (i_rvalid) resp(1'b1, i_rdata, i_err);
      if (d_rvalid) resp(1'b0, d_rdata, d_err);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) nxt();
    reset = 1'b0;

    // Reset values
    smp();
    chk("rst_ads", 32'(ads), 32'd0);
    chk("rst_rd_wr_n", 32'(rd_wr_n), 32'd1);
    chk("rst_i_dn", 32'(i_dn), 32'd1);
    chk("rst_addr", addr, 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    // I read alone, ack in cycle 2
    nxt(); i_req = 1'b1; i_addr = 32'h100;
    smp();
    chk("t1_i_gnt", 32'(i_gnt), 32'd1);
    chk("t1_ads_c0", 32'(ads), 32'd0);
    push(1'b1, 1'b0, 32'h0050_0093);
    nxt(); i_req = 1'b0;
    smp();
    chk("t1_ads_c1", 32'(ads), 32'd1);
    chk("t1_addr", addr, 32'h100);
    chk("t1_i_dn", 32'(i_dn), 32'd1);
    chk("t1_rd_wr_n", 32'(rd_wr_n), 32'd1);
    chk("t1_be", 32'(be), 32'hF);
    nxt(); ack = 1'b1; rd_data = 32'h0050_0093;
    smp();
    chk("t1_ads_c2", 32'(ads), 32'd0);
    chk("t1_rvalid_c2", 32'(i_rvalid), 32'd0);
    nxt(); ack = 1'b0; rd_data = '0;
    smp();
    chk("t1_rvalid_c3", 32'(i_rvalid), 32'd1);

    // D write, ack in the cycle after ads
    nxt(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_be = 4'h3; d_wdata = 32'hDEAD_BEEF;
    smp();
    chk("t2_d_gnt", 32'(d_gnt), 32'd1);
    push(1'b0, 1'b0, 32'h0);
    nxt(); d_req = 1'b0; d_we = 1'b0;
    smp();
    chk("t2_ads", 32'(ads), 32'd1);
    chk("t2_i_dn", 32'(i_dn), 32'd0);
    chk("t2_rd_wr_n", 32'(rd_wr_n), 32'd0);
    chk("t2_be", 32'(be), 32'h3);
    chk("t2_wr_data", wr_data, 32'hDEAD_BEEF);
    nxt(); ack = 1'b1; rd_data = 32'h1234_5678;
    smp();
    chk("t2_wait_be", 32'(be), 32'h3);
    chk("t2_wait_wr_data", wr_data, 32'hDEAD_BEEF);
    chk("t2_wait_rd_wr_n", 32'(rd_wr_n), 32'd0);
    nxt(); ack = 1'b0; rd_data = '0;
    smp();
    chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);

    // Conflict after reset: D, I, D, I with immediate acks
    nxt(); reset = 1'b1;
    nxt(); nxt(); reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h300; d_addr = 32'h400; d_be = 4'hF;
    for (int n = 0; n < 4; n++) begin
      logic exp_d;
      exp_d = (n % 2 == 0);
      smp();
      chk("t3_d_gnt", 32'(d_gnt), 32'(exp_d));
      chk("t3_i_gnt", 32'(i_gnt), 32'(!exp_d));
      chk("t3_ads_idle", 32'(ads), 32'd0);
      push(!exp_d, 1'b0, 32'hA000_0000 + 32'(n));
      nxt(); ack = 1'b1; rd_data = 32'hA000_0000 + 32'(n);
      smp();
      chk("t3_ads", 32'(ads), 32'd1);
      chk("t3_i_dn", 32'(i_dn), 32'(!exp_d));
      chk("t3_addr", addr, exp_d ? 32'h400 : 32'h300);
      nxt(); ack = 1'b0; rd_data = '0;
      if (n == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    smp();
    chk("t3_no_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);

    // Timeout on a D read, then the next request is granted
    nxt(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; rd_data = 32'hFFFF_FFFF;
    smp();
    chk("t4_d_gnt", 32'(d_gnt), 32'd1);
    push(1'b0, 1'b1, 32'h0);
    nxt(); d_req = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      smp();
      chk("t4_no_rvalid", 32'(d_rvalid), 32'd0);
      chk("t4_ads", 32'(ads), 32'(c == 1));
      nxt();
    end
    i_req = 1'b1; i_addr = 32'h104;
    smp();
    chk("t4_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t4_d_err", 32'(d_err), 32'd1);
    chk("t4_next_gnt", 32'(i_gnt), 32'd1);
    push(1'b1, 1'b0, 32'h13);
    nxt(); i_req = 1'b0;
    smp();
    chk("t4_next_ads", 32'(ads), 32'd1);
    nxt(); ack = 1'b1; rd_data = 32'h13;
    smp();
    nxt(); ack = 1'b0; rd_data = '0;
    smp();

    // Reset one cycle after ads aborts without a response
    nxt(); i_req = 1'b1; i_addr = 32'h600;
    smp();
    chk("t5_i_gnt", 32'(i_gnt), 32'd1);
    nxt(); i_req = 1'b0;
    smp();
    chk("t5_ads", 32'(ads), 32'd1);
    chk("t5_addr_pre", addr, 32'h600);
    nxt(); reset = 1'b1;
    #1;
    chk("t5_rst_ads", 32'(ads), 32'd0);
    chk("t5_rst_be", 32'(be), 32'd0);
    chk("t5_rst_addr", addr, 32'd0);
    nxt(); nxt(); reset = 1'b0;
    smp();
    nxt(); i_req = 1'b1; i_addr = 32'h700;
    smp();
    chk("t5_after_gnt", 32'(i_gnt), 32'd1);
    push(1'b1, 1'b0, 32'h77);
    nxt(); i_req = 1'b0;
    smp();
    chk("t5_after_addr", addr, 32'h700);
    nxt(); ack = 1'b1; rd_data = 32'h77;
    smp();
    nxt(); ack = 1'b0; rd_data = '0;
    smp();

    // Spurious ack in IDLE, then ack coinciding with timeout expiry
    nxt(); ack = 1'b1; rd_data = 32'h0000_0BAD;
    smp();
    chk("t6_idle_ads", 32'(ads), 32'd0);
    nxt();
    smp();
    chk("t6_idle_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    nxt(); ack = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    smp();
    chk("t6_d_gnt", 32'(d_gnt), 32'd1);
    push(1'b0, 1'b0, 32'hCAFE_F00D);
    nxt(); d_req = 1'b0;
    for (int c = 1; c < TO; c++) begin
      smp();
      chk("t6_no_rvalid", 32'(d_rvalid), 32'd0);
      nxt();
    end
    ack = 1'b1; rd_data = 32'hCAFE_F00D;
    smp();
    nxt(); ack = 1'b0; rd_data = '0;
    smp();
    chk("t6_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t6_d_err", 32'(d_err), 32'd0);
    nxt();
    smp();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
